// File: rtl/turn_controller.sv
// Two-player turn sequencer driving a per-turn timer: arms the timer each turn, reacts to moves and
// timeouts, requests auto-moves on timeout and declares forfeit after repeated consecutive timeouts.
module turn_controller #(
   parameter int TURN_SECONDS = 10,
   parameter int MAX_STRIKES  = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_game,
   input  logic       move_valid,
   input  logic       game_over,
   input  logic       timeout,
   input  logic [3:0] count_seconds,
   input  logic       auto_move_done,
   output logic       timer_enable,
   output logic       timer_reset,
   output logic       auto_move_req,
   output logic       current_player,
   output logic [7:0] turn_count,
   output logic [3:0] remaining_seconds,
   output logic       forfeit,
   output logic       winner,
   output logic [2:0] state_out
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_ARM       = 3'd1;
   localparam logic [2:0] S_WAIT_MOVE = 3'd2;
   localparam logic [2:0] S_AUTO_MOVE = 3'd3;
   localparam logic [2:0] S_SWITCH    = 3'd4;
   localparam logic [2:0] S_DONE      = 3'd5;

   localparam logic [4:0] TURN_S5 = 5'(TURN_SECONDS);
   localparam logic [1:0] MAX_S2  = 2'(MAX_STRIKES);

   logic [2:0] state_r;
   logic [2:0] state_s;
   logic       player_r;
   logic [7:0] turn_count_r;
   logic [1:0] strike_r [2];
   logic       forfeit_r;
   logic       winner_r;
   logic [1:0] strike_inc_s;
   logic [4:0] remaining_s;

   assign strike_inc_s = strike_r[player_r] + 2'd1;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decision; game_over outranks a move, which outranks a timeout
   always_comb begin
      state_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start_game) state_s = S_ARM;
            else            state_s = S_IDLE;
         end
         S_ARM: state_s = S_WAIT_MOVE;
         S_WAIT_MOVE: begin
            if (game_over)       state_s = S_DONE;
            else if (move_valid) state_s = S_SWITCH;
            else if (timeout) begin
               if (strike_inc_s == MAX_S2) state_s = S_DONE;
               else                        state_s = S_AUTO_MOVE;
            end else begin
               state_s = S_WAIT_MOVE;
            end
         end
         S_AUTO_MOVE: begin
            if (game_over)           state_s = S_DONE;
            else if (auto_move_done) state_s = S_SWITCH;
            else                     state_s = S_AUTO_MOVE;
         end
         S_SWITCH: state_s = S_ARM;
         S_DONE: begin
            if (start_game) state_s = S_ARM;
            else            state_s = S_DONE;
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Game bookkeeping: player, turn count, strike counters, forfeit result
   always_ff @(posedge clk) begin
      if (rst) begin
         player_r     <= 1'b0;
         turn_count_r <= 8'd0;
         strike_r[0]  <= 2'd0;
         strike_r[1]  <= 2'd0;
         forfeit_r    <= 1'b0;
         winner_r     <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE, S_DONE: begin
               if (start_game) begin
                  player_r     <= 1'b0;
                  turn_count_r <= 8'd0;
                  strike_r[0]  <= 2'd0;
                  strike_r[1]  <= 2'd0;
                  forfeit_r    <= 1'b0;
                  winner_r     <= 1'b0;
               end
            end
            S_WAIT_MOVE: begin
               if (!game_over) begin
                  if (move_valid) begin
                     strike_r[player_r] <= 2'd0;
                  end else if (timeout) begin
                     strike_r[player_r] <= strike_inc_s;
                     if (strike_inc_s == MAX_S2) begin
                        forfeit_r <= 1'b1;
                        winner_r  <= ~player_r;
                     end
                  end
               end
            end
            S_SWITCH: begin
               player_r <= ~player_r;
               if (turn_count_r != 8'hFF) turn_count_r <= turn_count_r + 8'd1;
            end
            default: ;
         endcase
      end
   end

   // Moore output decode from the state register only
   always_comb begin
      timer_reset   = 1'b0;
      timer_enable  = 1'b0;
      auto_move_req = 1'b0;
      case (state_r)
         S_ARM:       timer_reset   = 1'b1;
         S_WAIT_MOVE: timer_enable  = 1'b1;
         S_AUTO_MOVE: auto_move_req = 1'b1;
         default: ;
      endcase
   end

   // Seconds left in the turn, floored at zero once the timer overruns
   always_comb begin
      if ({1'b0, count_seconds} <= TURN_S5) remaining_s = TURN_S5 - {1'b0, count_seconds};
      else                                  remaining_s = 5'd0;
   end

   assign remaining_seconds = remaining_s[3:0];
   assign current_player    = player_r;
   assign turn_count        = turn_count_r;
   assign forfeit           = forfeit_r;
   assign winner            = winner_r;
   assign state_out         = state_r;

endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: a game-rules model tracks the expected outputs every cycle, directed
// scenarios pin key literal values, then randomized play exercises the remaining interleavings.
module tb_turn_controller;

   localparam int TS = 10;
   localparam int MS = 3;

   logic       clk = 1'b0;
   logic       rst, start_game, move_valid, game_over, timeout, auto_move_done;
   logic [3:0] count_seconds;
   logic       timer_enable, timer_reset, auto_move_req, current_player, forfeit, winner;
   logic [7:0] turn_count;
   logic [3:0] remaining_seconds;
   logic [2:0] state_out;

   int n_checks = 0;
   int n_fail   = 0;
   bit check_en = 1'b0;

   // model of the game: phase numbers are the published state_out codes
   int m_phase, m_player, m_turns, m_forfeit, m_winner;
   int m_strikes [2];

   turn_controller #(.TURN_SECONDS(TS), .MAX_STRIKES(MS)) dut (
      .clk(clk), .rst(rst), .start_game(start_game), .move_valid(move_valid),
      .game_over(game_over), .timeout(timeout), .count_seconds(count_seconds),
      .auto_move_done(auto_move_done), .timer_enable(timer_enable), .timer_reset(timer_reset),
      .auto_move_req(auto_move_req), .current_player(current_player), .turn_count(turn_count),
      .remaining_seconds(remaining_seconds), .forfeit(forfeit), .winner(winner),
      .state_out(state_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic new_game();
      m_player = 0; m_turns = 0; m_forfeit = 0; m_winner = 0;
      m_strikes[0] = 0; m_strikes[1] = 0;
   endtask

   // game rules applied at each rising edge
   always @(posedge clk) begin
      if (rst) begin
         m_phase = 0;
         new_game();
      end else if (m_phase == 0 || m_phase == 5) begin
         if (start_game) begin new_game(); m_phase = 1; end
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else if (m_phase == 2) begin
         if (game_over) m_phase = 5;
         else if (move_valid) begin m_strikes[m_player] = 0; m_phase = 4; end
         else if (timeout) begin
            m_strikes[m_player] += 1;
            if (m_strikes[m_player] == MS) begin
               m_forfeit = 1; m_winner = 1 - m_player; m_phase = 5;
            end else m_phase = 3;
         end
      end else if (m_phase == 3) begin
         if (game_over) m_phase = 5;
         else if (auto_move_done) m_phase = 4;
      end else if (m_phase == 4) begin
         m_player = 1 - m_player;
         m_turns  = (m_turns < 255) ? m_turns + 1 : 255;
         m_phase  = 1;
      end
   end

   // compare every cycle, mid-period
   always @(negedge clk) begin
      if (check_en) begin
         chk("state_out", int'(state_out), m_phase);
         chk("timer_reset", int'(timer_reset), int'(m_phase == 1));
         chk("timer_enable", int'(timer_enable), int'(m_phase == 2));
         chk("auto_move_req", int'(auto_move_req), int'(m_phase == 3));
         chk("current_player", int'(current_player), m_player);
         chk("turn_count", int'(turn_count), m_turns);
         chk("forfeit", int'(forfeit), m_forfeit);
         chk("winner", int'(winner), m_winner);
         chk("remaining_seconds", int'(remaining_seconds),
             (int'(count_seconds) <= TS) ? TS - int'(count_seconds) : 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // from WAIT_MOVE: time out, acknowledge the auto-move, end at the next player's WAIT_MOVE
   task automatic timeout_turn();
      timeout = 1'b1; tick(); timeout = 1'b0;
      chk("lit_timeout_auto", int'(state_out), 3);
      auto_move_done = 1'b1; tick(); auto_move_done = 1'b0;
      tick(); tick();
   endtask

   task automatic move_turn();
      move_valid = 1'b1; tick(); move_valid = 1'b0;
      tick(); tick();
   endtask

   initial begin
      rst = 1'b1; start_game = 1'b0; move_valid = 1'b0; game_over = 1'b0;
      timeout = 1'b0; auto_move_done = 1'b0; count_seconds = 4'd0;
      tick(); check_en = 1'b1;
      chk("lit_reset_state", int'(state_out), 0);
      tick(); rst = 1'b0;

      // start: one ARM cycle then timer running
      start_game = 1'b1; tick(); start_game = 1'b0;
      chk("lit_arm", int'(timer_reset), 1);
      tick();
      chk("lit_enable", int'(timer_enable), 1);
      chk("lit_remaining10", int'(remaining_seconds), 10);
      count_seconds = 4'd3; #1;
      chk("lit_remaining7", int'(remaining_seconds), 7);

      // normal move
      move_valid = 1'b1; tick(); move_valid = 1'b0;
      chk("lit_switch", int'(state_out), 4);
      tick();
      chk("lit_player1", int'(current_player), 1);
      chk("lit_turns1", int'(turn_count), 1);
      tick();

      // timeout with a slow auto-move ack
      timeout = 1'b1; tick(); timeout = 1'b0;
      chk("lit_req", int'(auto_move_req), 1);
      count_seconds = 4'd12; #1;
      chk("lit_remaining_floor", int'(remaining_seconds), 0);
      repeat (5) tick();
      chk("lit_still_auto", int'(state_out), 3);
      auto_move_done = 1'b1; tick(); auto_move_done = 1'b0;
      tick(); tick();
      count_seconds = 4'd0;

      // player index 0 strikes, cleared by an own move, then forfeits on the third in a row
      timeout_turn(); move_turn();
      timeout_turn(); move_turn();
      move_turn();    move_turn();
      timeout_turn(); move_turn();
      timeout_turn(); move_turn();
      timeout = 1'b1; tick(); timeout = 1'b0;
      chk("lit_forfeit_state", int'(state_out), 5);
      chk("lit_forfeit", int'(forfeit), 1);
      chk("lit_winner", int'(winner), 1);
      chk("lit_no_req", int'(auto_move_req), 0);
      move_valid = 1'b1; timeout = 1'b1; tick(); move_valid = 1'b0; timeout = 1'b0;
      chk("lit_done_holds", int'(state_out), 5);

      // restart, then simultaneous events
      start_game = 1'b1; tick(); start_game = 1'b0;
      chk("lit_restart_turns", int'(turn_count), 0);
      tick();
      move_valid = 1'b1; timeout = 1'b1; tick(); move_valid = 1'b0; timeout = 1'b0;
      chk("lit_move_beats_timeout", int'(state_out), 4);
      tick(); tick();
      game_over = 1'b1; move_valid = 1'b1; tick(); game_over = 1'b0; move_valid = 1'b0;
      chk("lit_gameover_done", int'(state_out), 5);
      chk("lit_gameover_turns", int'(turn_count), 1);

      // reset during AUTO_MOVE
      start_game = 1'b1; tick(); start_game = 1'b0; tick();
      timeout = 1'b1; tick(); timeout = 1'b0;
      rst = 1'b1; tick(); rst = 1'b0;
      chk("lit_rst_idle", int'(state_out), 0);
      chk("lit_rst_req", int'(auto_move_req), 0);

      // turn counter saturation
      start_game = 1'b1; tick(); start_game = 1'b0; tick();
      repeat (256) move_turn();
      chk("lit_saturate", int'(turn_count), 255);

      // randomized play
      for (int i = 0; i < 3000; i++) begin
         rst            = ($urandom_range(0, 199) == 0);
         start_game     = ($urandom_range(0, 9) == 0);
         move_valid     = ($urandom_range(0, 5) == 0);
         timeout        = ($urandom_range(0, 6) == 0);
         game_over      = ($urandom_range(0, 39) == 0);
         auto_move_done = ($urandom_range(0, 3) == 0);
         count_seconds  = 4'($urandom_range(0, 15));
         tick();
      end
      rst = 1'b0;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
